// File: rtl/one_hot_div_ctrl.sv
// Run/stop and ratio controller for the one-hot ring clock divider.
// Ratio changes and stops are deferred to period boundaries so o_clk never emits a runt pulse.
module one_hot_div_ctrl #(
    parameter int MAX_N = 16,
    parameter int DEF_N = 8,
    parameter int DW    = 5
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_en,
    input  logic          i_cfg_valid,
    input  logic [DW-1:0] i_cfg_div,
    output logic          o_cfg_ready,
    output logic          o_cfg_err,
    output logic          o_clk,
    output logic          o_tick,
    output logic [MAX_N-1:0] o_ring,
    output logic [DW-1:0] o_div_cur,
    output logic [1:0]    o_state
);

    typedef enum logic [1:0] {
        ST_STOP = 2'b00,
        ST_RUN  = 2'b01,
        ST_PEND = 2'b10
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [MAX_N-1:0]   r_ring, w_ring_nxt, w_ring_adv;
    logic [DW-1:0]      r_pos, w_pos_nxt, w_pos_adv;
    logic [DW-1:0]      r_div_cur, w_div_cur_nxt;
    logic [DW-1:0]      r_div_nxt, w_div_nxt_nxt;
    logic               r_clk, w_clk_nxt;
    logic               r_tick, w_tick_nxt;
    logic               r_cfg_err, w_cfg_err_nxt;
    logic               w_xfer, w_legal, w_last, w_running_nxt;

    function automatic logic f_ratio_legal(input logic [DW-1:0] div);
        return (div >= DW'(2)) && (div <= DW'(MAX_N));
    endfunction

    assign o_cfg_ready = (r_state != ST_PEND);
    assign o_cfg_err   = r_cfg_err;
    assign o_clk       = r_clk;
    assign o_tick      = r_tick;
    assign o_ring      = r_ring;
    assign o_div_cur   = r_div_cur;
    assign o_state     = r_state;

    assign w_xfer     = i_cfg_valid & o_cfg_ready;
    assign w_legal    = f_ratio_legal(i_cfg_div);
    assign w_last     = (r_pos == (r_div_cur - DW'(1)));
    assign w_pos_adv  = w_last ? DW'(0) : (r_pos + DW'(1));
    assign w_ring_adv = w_last ? MAX_N'(1) : {r_ring[MAX_N-2:0], 1'b0};

    // Next-state, token and ratio selection; o_clk/o_tick are precomputed for the next cycle.
    always_comb begin
        w_state_nxt   = r_state;
        w_pos_nxt     = r_pos;
        w_ring_nxt    = r_ring;
        w_div_cur_nxt = r_div_cur;
        w_div_nxt_nxt = r_div_nxt;
        w_cfg_err_nxt = w_xfer & ~w_legal;

        case (r_state)
            ST_STOP: begin
                w_pos_nxt  = DW'(0);
                w_ring_nxt = MAX_N'(1);
                if (w_xfer && w_legal) begin
                    w_div_cur_nxt = i_cfg_div;
                end else begin
                    w_div_cur_nxt = r_div_cur;
                end
                if (i_en) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_STOP;
                end
            end
            ST_RUN: begin
                w_pos_nxt  = w_pos_adv;
                w_ring_nxt = w_ring_adv;
                // A legal offer wins over a stop request; the stop is resolved at the PEND boundary.
                if (w_xfer && w_legal) begin
                    w_div_nxt_nxt = i_cfg_div;
                    w_state_nxt   = ST_PEND;
                end else if (w_last && !i_en) begin
                    w_state_nxt = ST_STOP;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_PEND: begin
                w_pos_nxt  = w_pos_adv;
                w_ring_nxt = w_ring_adv;
                if (w_last) begin
                    w_div_cur_nxt = r_div_nxt;
                    w_state_nxt   = i_en ? ST_RUN : ST_STOP;
                end else begin
                    w_state_nxt = ST_PEND;
                end
            end
            default: begin
                w_state_nxt   = ST_STOP;
                w_pos_nxt     = DW'(0);
                w_ring_nxt    = MAX_N'(1);
                w_div_cur_nxt = DW'(DEF_N);
            end
        endcase

        w_running_nxt = (w_state_nxt != ST_STOP);
        w_clk_nxt     = w_running_nxt && (w_pos_nxt < (w_div_cur_nxt >> 1));
        w_tick_nxt    = w_running_nxt && (w_pos_nxt == DW'(0));
    end

    // State, token and output registers with synchronous reset priority.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_STOP;
            r_pos     <= DW'(0);
            r_ring    <= MAX_N'(1);
            r_div_cur <= DW'(DEF_N);
            r_div_nxt <= DW'(DEF_N);
            r_clk     <= 1'b0;
            r_tick    <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pos     <= w_pos_nxt;
            r_ring    <= w_ring_nxt;
            r_div_cur <= w_div_cur_nxt;
            r_div_nxt <= w_div_nxt_nxt;
            r_clk     <= w_clk_nxt;
            r_tick    <= w_tick_nxt;
            r_cfg_err <= w_cfg_err_nxt;
        end
    end

endmodule

// File: tb/tb_one_hot_div_ctrl.sv
// Scoreboard bench: a behavioural model pushes expected outputs per driven cycle, popped after the edge.
module tb_one_hot_div_ctrl;
    localparam int MAX_N = 16;
    localparam int DEF_N = 8;
    localparam int DW    = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             i_rst = 1'b1, i_en = 1'b0, i_cfg_valid = 1'b0;
    logic [DW-1:0]    i_cfg_div = '0;
    logic             o_cfg_ready, o_cfg_err, o_clk, o_tick;
    logic [MAX_N-1:0] o_ring;
    logic [DW-1:0]    o_div_cur;
    logic [1:0]       o_state;

    one_hot_div_ctrl #(.MAX_N(MAX_N), .DEF_N(DEF_N), .DW(DW)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_en(i_en), .i_cfg_valid(i_cfg_valid),
        .i_cfg_div(i_cfg_div), .o_cfg_ready(o_cfg_ready), .o_cfg_err(o_cfg_err),
        .o_clk(o_clk), .o_tick(o_tick), .o_ring(o_ring), .o_div_cur(o_div_cur),
        .o_state(o_state)
    );

    typedef struct packed {
        logic [MAX_N-1:0] ring;
        logic             clk;
        logic             tick;
        logic [DW-1:0]    div;
        logic [1:0]       st;
        logic             rdy;
        logic             err;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // behavioural model state: 0 STOP, 1 RUN, 2 PEND
    int   m_state = 0, m_p = 0, m_div = DEF_N, m_nxt = DEF_N;
    logic m_err = 1'b0;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input logic rst, input logic en, input logic v, input int d);
        bit last, hs, legal;
        if (rst) begin
            m_state = 0; m_p = 0; m_div = DEF_N; m_nxt = DEF_N; m_err = 1'b0;
        end else begin
            last  = (m_p == m_div - 1);
            hs    = v && (m_state != 2);
            legal = (d >= 2) && (d <= MAX_N);
            m_err = hs && !legal;
            case (m_state)
                0: begin
                    if (hs && legal) m_div = d;
                    m_p = 0;
                    if (en) m_state = 1;
                end
                1: begin
                    m_p = last ? 0 : m_p + 1;
                    if (hs && legal) begin
                        m_nxt = d; m_state = 2;
                    end else if (last && !en) m_state = 0;
                end
                default: begin
                    m_p = last ? 0 : m_p + 1;
                    if (last) begin
                        m_div = m_nxt; m_state = en ? 1 : 0;
                    end
                end
            endcase
        end
    endtask

    function automatic exp_t model_exp();
        exp_t e;
        bit run;
        run    = (m_state != 0);
        e.ring = MAX_N'(1) << m_p;
        e.clk  = run && (m_p < m_div / 2);
        e.tick = run && (m_p == 0);
        e.div  = DW'(m_div);
        e.st   = 2'(m_state);
        e.rdy  = (m_state != 2);
        e.err  = m_err;
        return e;
    endfunction

    task automatic step(input logic rst, input logic en, input logic v, input int d);
        exp_t e;
        @(negedge clk);
        i_rst = rst; i_en = en; i_cfg_valid = v; i_cfg_div = DW'(d);
        model_edge(rst, en, v, d);
        sb_q.push_back(model_exp());
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk_val("ring",  o_ring,      e.ring);
        chk_val("clk",   o_clk,       e.clk);
        chk_val("tick",  o_tick,      e.tick);
        chk_val("div",   o_div_cur,   e.div);
        chk_val("state", o_state,     e.st);
        chk_val("ready", o_cfg_ready, e.rdy);
        chk_val("err",   o_cfg_err,   e.err);
    endtask

    task automatic run_n(input int n, input logic en);
        for (int k = 0; k < n; k++) step(1'b0, en, 1'b0, 0);
    endtask

    task automatic run_to_p(input int p);
        for (int k = 0; k < MAX_N + 1 && m_p != p; k++) step(1'b0, 1'b1, 1'b0, 0);
    endtask

    initial begin
        // 1: reset then run at the default ratio
        step(1'b1, 1'b0, 1'b0, 0);
        step(1'b1, 1'b0, 1'b0, 0);
        chk_val("rst_ring",  o_ring,      32'h0001);
        chk_val("rst_div",   o_div_cur,   32'd8);
        chk_val("rst_state", o_state,     32'd0);
        chk_val("rst_ready", o_cfg_ready, 32'd1);
        run_n(20, 1'b1);

        // 3: illegal ratios complete the handshake and only pulse the error
        step(1'b0, 1'b1, 1'b1, 1);
        run_n(3, 1'b1);
        step(1'b0, 1'b1, 1'b1, 17);
        run_n(10, 1'b1);
        chk_val("illegal_div", o_div_cur, 32'd8);

        // 4: stop request mid-period, restart later
        run_to_p(2);
        run_n(12, 1'b0);
        chk_val("stopped_clk",  o_clk,   32'd0);
        chk_val("stopped_ring", o_ring,  32'h0001);
        run_n(17, 1'b1);

        // 2: ratio change offered at p=3 applies at the wrap
        run_to_p(3);
        step(1'b0, 1'b1, 1'b1, 5);
        chk_val("pend_ready", o_cfg_ready, 32'd0);
        run_n(16, 1'b1);
        chk_val("new_div", o_div_cur, 32'd5);

        // 5: reset in the middle of PEND discards the pending ratio
        step(1'b0, 1'b1, 1'b1, 3);
        step(1'b1, 1'b1, 1'b0, 0);
        chk_val("pend_rst_div", o_div_cur, 32'd8);
        run_n(18, 1'b1);

        // 6: ratio change in STOP, then a handshake on the wrap cycle
        run_to_p(7);
        run_n(3, 1'b0);
        step(1'b0, 1'b0, 1'b1, 2);
        run_n(7, 1'b1);
        run_to_p(1);
        step(1'b0, 1'b1, 1'b1, 16);
        run_n(36, 1'b1);

        // handshake together with a stop request at the last position
        run_to_p(15);
        step(1'b0, 1'b0, 1'b1, 4);
        run_n(24, 1'b0);
        chk_val("final_div", o_div_cur, 32'd4);
        run_n(9, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/one_hot_div_ctrl.md
Name: one_hot_div_ctrl

Overview:
Run/stop and ratio controller for the one-hot ring clock divider, driven from i_clk (CLOCK_50 domain).
- Owns a MAX_N-bit one-hot token ring and the active division ratio.
- Accepts new ratios over a valid/ready handshake.
- Applies ratio changes and stops only at period boundaries, so the divided clock on GPIO never emits a runt pulse.

Parameters:
MAX_N, 16, ring length and largest legal division ratio (>=2)
DEF_N, 8, ratio loaded at reset (2..MAX_N)
DW, 5, width of ratio fields; must hold MAX_N ($clog2(MAX_N+1))

Ports:
i_clk  in  1  system clock; one clock domain
i_rst  in  1  reset, synchronous, active-high
i_en  in  1  run enable, level
i_cfg_valid  in  1  new ratio offered
i_cfg_div  in  DW  requested ratio
o_cfg_ready  out  1  controller can accept a ratio
o_cfg_err  out  1  one-cycle pulse: offered ratio illegal
o_clk  out  1  divided clock (drive to GPIO[0])
o_tick  out  1  one-cycle pulse at start of each period
o_ring  out  MAX_N  one-hot token, bit p = current position
o_div_cur  out  DW  active ratio
o_state  out  2  00 STOP, 01 RUN, 10 PEND

Behaviour:
- Reset (i_rst=1 at a clock edge) gives these values on the next cycle:
  - state STOP, o_div_cur=DEF_N, o_ring=1 (token at 0), o_clk=0, o_tick=0;
  - o_cfg_ready=1, o_cfg_err=0;
  - any pending ratio is discarded.
- Reset has priority over every other input, including mid-PEND and mid-period.
- Token position p: 0..o_div_cur-1. In RUN/PEND p advances by one per cycle; after o_div_cur-1 it wraps to 0. In STOP it is held at 0.
- o_clk comes from a flop, not a decode. It is 1 exactly in RUN/PEND cycles with p < (o_div_cur>>1), else 0.
  - Even ratio: 50% duty. Odd ratio: floor(N/2) cycles high, ceil(N/2) cycles low.
- o_tick=1 exactly in RUN/PEND cycles with p=0.
- STOP:
  - i_en=1 sampled → RUN next cycle with p=0 (o_tick=1, o_clk=1 in that cycle).
  - Handshake with a legal ratio → o_div_cur updates next cycle; state stays STOP.
- RUN:
  - i_en=0 sampled while p=o_div_cur-1 → STOP next cycle. Otherwise keep running; the current period always completes.
  - i_en re-asserted before the last position → no effect.
  - Legal handshake → ratio latched into a hidden div_nxt register; state PEND next cycle; o_cfg_ready=0.
- PEND:
  - Token keeps advancing at the old ratio.
  - In the cycle with p=o_div_cur-1: next cycle o_div_cur<=div_nxt and p=0.
  - Next state is RUN if i_en=1, STOP if i_en=0.
  - o_cfg_ready returns to 1 in that same next cycle.
- Handshake: a transfer occurs when i_cfg_valid & o_cfg_ready. o_cfg_ready=1 in STOP and RUN, 0 in PEND.
- Legality: 2 <= i_cfg_div <= MAX_N.
  - An illegal value still completes the handshake.
  - o_cfg_err=1 for the following cycle only; no state or ratio change.
- Simultaneous events:
  - Handshake in a RUN cycle with p=o_div_cur-1 → PEND. The new ratio applies after one further full old period, not immediately.
  - Handshake and i_en=0 at the last position → PEND. The ratio is applied at the next boundary, then STOP.
- Ratio changes take effect only at p wrap. Shrinking or growing never truncates or stretches the current period.

Test Plan:
1. Reset, then i_en=1 (DEF_N=8) → o_ring steps 0x0001,0x0002..0x0080,0x0001; o_clk 4 high/4 low; o_tick every 8 cycles, coincident with o_ring=0x0001.
2. RUN at p=3, offer div=5 → o_cfg_ready low, state PEND.
   - The 8-cycle period completes (4 more cycles), then o_div_cur=5 and ready=1.
   - o_clk then runs 2 high/3 low; o_tick every 5.
3. Offer div=1, then div=17 → handshake completes, o_cfg_err pulses one cycle each; o_div_cur stays 8; o_clk waveform uninterrupted.
4. i_en=0 at p=2 → token runs to p=7, then STOP (o_ring=0x0001, o_clk=0). Re-assert i_en after 3 cycles → o_tick on the next cycle and clean 4/4 periods.
5. Reset during PEND (div_nxt=3) → next cycle STOP, o_div_cur=8, o_cfg_ready=1; enabling yields period 8, not 3.
6. In STOP offer div=2, then i_en=1 → o_div_cur=2 immediately; o_clk toggles every cycle; o_tick every 2 cycles. Also offer div=16 with handshake on the wrap cycle → one more 2-cycle period, then period 16.
